// File: rtl/controle_acumulador.sv
// Clocked accumulator/ALU controller: single-cycle ops plus a WIDTH-cycle shift-and-add multiply.
// Optional build macro SATURATE_EN: clamp add/multiply overflow to all-ones and subtract borrow to zero.
module controle_acumulador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       Op,
  input  logic             op_valid,
  output logic             op_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] saida,
  output logic             overflow,
  output logic             done
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam int CW = $clog2(WIDTH + 1);

  logic [0:0]         state;
  logic [WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum, diff;
  logic               carry, borrow, mul_ovf, mul_last;
  logic [WIDTH-1:0]   add_res, sub_res, mul_res;

  assign op_ready = (state == IDLE);
  assign acc_out  = acc;

  assign sum      = {1'b0, acc} + {1'b0, A};
  assign diff     = {1'b0, acc} - {1'b0, A};
  assign carry    = sum[WIDTH];
  assign borrow   = diff[WIDTH];
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign mul_ovf  = |prod_nxt[2*WIDTH-1:WIDTH];
  assign mul_last = (cnt == CW'(WIDTH - 1));

`ifdef SATURATE_EN
  assign add_res = carry   ? '1 : sum[WIDTH-1:0];
  assign sub_res = borrow  ? '0 : diff[WIDTH-1:0];
  assign mul_res = mul_ovf ? '1 : prod_nxt[WIDTH-1:0];
`else
  assign add_res = sum[WIDTH-1:0];
  assign sub_res = diff[WIDTH-1:0];
  assign mul_res = prod_nxt[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      saida    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      mcand    <= '0;
      prod     <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        // op_ready is high in IDLE, so op_valid alone means accept
        if (op_valid) begin
          done <= (Op != 3'b111);
          case (Op)
            3'b000: begin acc <= '0; saida <= '0; overflow <= 1'b0; end
            3'b001: begin acc <= A; overflow <= 1'b0; end
            3'b010: ;
            3'b011: begin acc <= add_res; if (carry) overflow <= 1'b1; end
            3'b100: acc <= acc >> 1;
            3'b101: saida <= acc;
            3'b110: begin acc <= sub_res; if (borrow) overflow <= 1'b1; end
            default: begin
              state  <= MUL;
              mcand  <= {{WIDTH{1'b0}}, acc};
              mplier <= A;
              prod   <= '0;
              cnt    <= '0;
            end
          endcase
        end
      end else begin
        prod   <= prod_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          acc   <= mul_res;
          state <= IDLE;
          done  <= 1'b1;
          if (mul_ovf) overflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/controle_acumulador.md
Name: controle_acumulador

Overview:
Parametrised, clocked accumulator/ALU controller and the successor of the 4-bit combinational calculator controller. It executes one 3-bit opcode per accepted request against a WIDTH-bit accumulator. The opcodes are clear, load, hold, add, halve, display, subtract and an iterative multiply. It keeps a sticky overflow flag and a separate display register, and sits between the operand/opcode source (keypad/switch logic) and the display driver.

Parameters:
WIDTH, 4, bit width of operand A, accumulator, display register and multiplier datapath (legal 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
A  input  WIDTH  operand (entrada), sampled only on accept
Op  input  3  opcode, sampled only on accept
op_valid  input  1  request strobe; A/Op are valid while high
op_ready  output  1  block can accept a request this cycle
acc_out  output  WIDTH  accumulator contents
saida  output  WIDTH  display register
overflow  output  1  sticky overflow/borrow flag
done  output  1  one-cycle pulse, operation finished

Behaviour:
- Reset (rst_n low, async): acc_out=0, saida=0, overflow=0, done=0, state=IDLE, op_ready=1. Applies immediately, including mid-multiply; the multiply is aborted with no partial result kept.
- States: IDLE, MUL. op_ready = (state==IDLE), combinational from state.
- Accept = op_valid & op_ready at a rising edge. op_valid while op_ready=0 is ignored; the requester holds it.
- Single-cycle ops update acc/saida/overflow at the accepting edge. done=1 for exactly the following cycle. Back-to-back accepts are allowed every cycle.
- 000 clear: acc=0, saida=0, overflow=0.
- 001 load: acc=A, overflow=0.
- 010 hold: no state change; done still pulses.
- 011 add: acc=(acc+A) mod 2^WIDTH. If the carry out of the MSB is 1, overflow is set.
- 100 halve: acc=acc>>1, logical, LSB discarded. overflow unchanged.
- 101 display: saida=acc. This is the only op besides clear that writes saida.
- 110 subtract: acc=(acc-A) mod 2^WIDTH. If A>acc (borrow), overflow is set.
- 111 multiply: latch multiplicand=acc, multiplier=A, go to MUL.
  - Shift-and-add, one multiplier bit per cycle, for exactly WIDTH cycles, with a 2*WIDTH-bit internal product.
  - acc stays unchanged until the last MUL cycle. At that edge acc = low WIDTH bits of the product, and state returns to IDLE.
  - If any upper product bit is 1, overflow is set.
  - done=1 in the cycle after that edge.
  - Total: accept edge k, result edge k+WIDTH, op_ready=0 for WIDTH cycles.
- overflow is sticky. Only clear, load or reset lower it. Ops that do not overflow never clear it.
- Zero operand edge cases: A=0 multiply gives acc=0 with no overflow; acc=0 halve gives 0.

Optional Feature:
SATURATE_EN
- Defined:
  - add overflow forces acc to all-ones (2^WIDTH-1).
  - subtract borrow forces acc to 0.
  - multiply overflow forces acc to all-ones.
  - overflow is still set exactly as in wrap mode.
- Undefined: modulo-2^WIDTH wrap as specified above.
- Timing and handshake are identical in both builds.

Test Plan:
1. WIDTH=4: reset, load 9, add 8 -> acc_out=1, overflow=1, done pulse after each op. Same sequence with SATURATE_EN -> acc_out=15, overflow=1.
2. Load 6, halve x3 -> acc_out 3, 1, 0; overflow stays 0. Then load 3, subtract 5 -> acc_out=14 (SATURATE_EN: 0), overflow=1. Then load 2 -> overflow=0.
3. Multiply:
   - load 5, multiply 3 -> op_ready low 4 cycles, acc_out=15 at edge k+4, done next cycle, overflow=0.
   - load 5, multiply 4 -> acc_out=4, overflow=1.
   - op_valid with load 1 held during MUL -> ignored until op_ready rises, then accepted.
4. Load 7, display -> saida=7. Load 2, add 1 -> saida stays 7, acc_out=3. Clear -> saida=0, acc_out=0.
5. Load 5, multiply 3, assert rst_n low on the 2nd MUL cycle -> all outputs 0 immediately. After release op_ready=1, and a subsequent load 4 gives acc_out=4.
6. Hold issued on 3 consecutive cycles after load 10 -> acc_out stays 10, done high on 3 consecutive cycles, op_ready stays 1.
